// File: rtl/dmem_io_bus_if.sv
// Core data-memory port: address, store data and strobe towards memory, load data back.
// Latency: none of its own; rdata timing is set by the slave.
// Backpressure: none, the slave accepts one access every cycle.
interface dmem_io_bus_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic [31:0] rdata;

    modport master (
        output addr,
        output wdata,
        output mem_write,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wdata,
        input  mem_write,
        output rdata
    );
endinterface

// File: rtl/dmem_io_bus.sv
// Data-side memory: word RAM plus an I/O page (LED, cycle counter, countdown timer with irq).
// Latency: loads are combinational; stores commit at the rising edge and are readable next cycle.
// Backpressure: none, every access completes in its own cycle.
module dmem_io_bus #(
    parameter int          RAM_DEPTH = 1024,
    parameter logic [31:0] IO_BASE   = 32'h0000_7F00,
    parameter int          LED_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    dmem_io_bus_if.slave     bus,
    output logic [LED_W-1:0] led,
    output logic             timer_irq
);
    localparam int          AW        = $clog2(RAM_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_DEPTH * 4);

    // Word offsets inside the I/O page (byte offset >> 2).
    localparam logic [5:0] OFF_LED    = 6'h00;
    localparam logic [5:0] OFF_CYCLE  = 6'h01;
    localparam logic [5:0] OFF_PRESET = 6'h02;
    localparam logic [5:0] OFF_COUNT  = 6'h03;
    localparam logic [5:0] OFF_CTRL   = 6'h04;

    logic [31:0]      ram [RAM_DEPTH];

    logic [LED_W-1:0] led_q;
    logic [31:0]      cycle_q;
    logic [31:0]      preset_q;
    logic [31:0]      count_q;
    logic             en_q;
    logic             reload_q;
    logic             irq_en_q;
    logic             irq_flag_q;

    logic             ram_hit;
    logic             io_hit;
    logic [AW-1:0]    ram_idx;
    logic [5:0]       io_off;
    logic             wr_led;
    logic             wr_cycle;
    logic             wr_preset;
    logic             wr_ctrl;
    logic             tmr_expire;

    // RAM takes priority; the I/O page sits outside the RAM span for the default sizing.
    assign ram_hit = (bus.addr < RAM_BYTES);
    assign io_hit  = !ram_hit && (bus.addr[31:8] == IO_BASE[31:8]);
    assign ram_idx = bus.addr[AW+1:2];
    assign io_off  = bus.addr[7:2];

    assign wr_led    = bus.mem_write && io_hit && (io_off == OFF_LED);
    assign wr_cycle  = bus.mem_write && io_hit && (io_off == OFF_CYCLE);
    assign wr_preset = bus.mem_write && io_hit && (io_off == OFF_PRESET);
    assign wr_ctrl   = bus.mem_write && io_hit && (io_off == OFF_CTRL);

    // Timer reaches its terminal step this edge; drives both the flag and the reload.
    assign tmr_expire = en_q && (count_q == 32'd1);

    // RAM store port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (bus.mem_write && ram_hit) begin
            ram[ram_idx] <= bus.wdata;
        end
    end

    // LED register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q <= '0;
        end else if (wr_led) begin
            led_q <= bus.wdata[LED_W-1:0];
        end
    end

    // Free-running cycle counter; a store to it clears it instead of incrementing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= '0;
        end else if (wr_cycle) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    // Timer preset register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            preset_q <= '0;
        end else if (wr_preset) begin
            preset_q <= bus.wdata;
        end
    end

    // Countdown: a preset store reloads immediately and overrides the decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (wr_preset) begin
            count_q <= bus.wdata;
        end else if (en_q) begin
            if (count_q > 32'd1) begin
                count_q <= count_q - 32'd1;
            end else if (count_q == 32'd1) begin
                count_q <= reload_q ? preset_q : 32'd0;
            end
        end
    end

    // Control bits; new settings govern the timer from the following edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q     <= 1'b0;
            reload_q <= 1'b0;
            irq_en_q <= 1'b0;
        end else if (wr_ctrl) begin
            en_q     <= bus.wdata[0];
            reload_q <= bus.wdata[1];
            irq_en_q <= bus.wdata[3];
        end
    end

    // Sticky interrupt flag; a new expiry beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_flag_q <= 1'b0;
        end else if (tmr_expire) begin
            irq_flag_q <= 1'b1;
        end else if (wr_ctrl && bus.wdata[2]) begin
            irq_flag_q <= 1'b0;
        end
    end

    // Load data mux; reflects state before any store landing this edge.
    always_comb begin
        bus.rdata = '0;
        if (ram_hit) begin
            bus.rdata = ram[ram_idx];
        end else if (io_hit) begin
            case (io_off)
                OFF_LED:    bus.rdata = 32'(led_q);
                OFF_CYCLE:  bus.rdata = cycle_q;
                OFF_PRESET: bus.rdata = preset_q;
                OFF_COUNT:  bus.rdata = count_q;
                OFF_CTRL:   bus.rdata = {28'd0, irq_en_q, irq_flag_q, reload_q, en_q};
                default:    bus.rdata = '0;
            endcase
        end
    end

    assign led       = led_q;
    assign timer_irq = irq_flag_q && irq_en_q;
endmodule

// File: tb/tb_dmem_io_bus.sv
module tb_dmem_io_bus;
    localparam logic [31:0] A_LED    = 32'h0000_7F00;
    localparam logic [31:0] A_CYCLE  = 32'h0000_7F04;
    localparam logic [31:0] A_PRESET = 32'h0000_7F08;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F0C;
    localparam logic [31:0] A_CTRL   = 32'h0000_7F10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] led;
    logic        timer_irq;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb [$];

    dmem_io_bus_if bus ();

    dmem_io_bus #(
        .RAM_DEPTH(1024),
        .IO_BASE  (32'h0000_7F00),
        .LED_W    (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .led      (led),
        .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    // Pop the oldest expectation and compare it with an observed value.
    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    // Combinational load: present the address, let it settle, check.
    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus.addr      = a;
        bus.mem_write = 1'b0;
        sb.push_back(exp);
        #1;
        check(tag, bus.rdata);
    endtask

    task automatic sig(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        sb.push_back(exp);
        check(tag, obs);
    endtask

    // Store committed at the next rising edge; returns 1 time unit after it.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr      = a;
        bus.wdata     = d;
        bus.mem_write = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_write = 1'b0;

        // Reset state
        #2;
        sig(32'(led), 32'h0, "rst_led");
        sig(32'(timer_irq), 32'h0, "rst_irq");
        rd(A_LED, 32'h0, "rst_led_rd");
        rd(A_COUNT, 32'h0, "rst_count");
        rd(A_CTRL, 32'h0, "rst_ctrl");
        rd(A_PRESET, 32'h0, "rst_preset");
        rd(A_CYCLE, 32'h0, "rst_cycle");
        @(negedge clk);
        rst = 1'b0;
        tick(1);

        // RAM store/load and ignored byte offset
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, 32'hDEAD_BEEF, "ram_rd");
        rd(32'h13, 32'hDEAD_BEEF, "ram_rd_unaligned");
        // Load of the word being stored this cycle returns the old value
        @(negedge clk);
        bus.addr      = 32'h10;
        bus.wdata     = 32'h1111_1111;
        bus.mem_write = 1'b1;
        #1;
        sig(bus.rdata, 32'hDEAD_BEEF, "ram_same_cycle_old");
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
        rd(32'h10, 32'h1111_1111, "ram_new");
        wr(32'hFFC, 32'h0BAD_F00D);
        rd(32'hFFC, 32'h0BAD_F00D, "ram_top_word");

        // Unmapped store is dropped
        wr(32'h0001_0000, 32'h1234);
        rd(32'h0001_0000, 32'h0, "unmapped_rd");
        rd(32'h10, 32'h1111_1111, "unmapped_ram_kept");
        rd(A_LED, 32'h0, "unmapped_led_kept");
        rd(A_PRESET, 32'h0, "unmapped_preset_kept");
        rd(32'h0000_7F20, 32'h0, "io_hole_rd");

        // LED register: low 16 bits only
        wr(A_LED, 32'hFFFF_FFA5);
        rd(A_LED, 32'h0000_FFA5, "led_rd");
        sig(32'(led), 32'h0000_FFA5, "led_port");

        // Cycle counter: clear, then counts one per edge
        wr(A_CYCLE, 32'hFFFF_FFFF);
        rd(A_CYCLE, 32'h0, "cycle_clear");
        tick(1);
        rd(A_CYCLE, 32'h1, "cycle_one");
        tick(5);
        rd(A_CYCLE, 32'h6, "cycle_plus5");

        // One-shot timer
        wr(A_PRESET, 32'd3);
        rd(A_COUNT, 32'd3, "os_load");
        wr(A_CTRL, 32'h9);
        rd(A_COUNT, 32'd3, "os_en_edge");
        rd(A_CTRL, 32'h9, "os_ctrl");
        tick(1);
        rd(A_COUNT, 32'd2, "os_c2");
        tick(1);
        rd(A_COUNT, 32'd1, "os_c1");
        sig(32'(timer_irq), 32'h0, "os_irq_low");
        tick(1);
        rd(A_COUNT, 32'd0, "os_c0");
        rd(A_CTRL, 32'hD, "os_flag");
        sig(32'(timer_irq), 32'h1, "os_irq_high");
        tick(2);
        rd(A_COUNT, 32'd0, "os_hold");
        sig(32'(timer_irq), 32'h1, "os_irq_sticky");
        wr(A_CTRL, 32'h4);
        rd(A_CTRL, 32'h0, "os_w1c");
        sig(32'(timer_irq), 32'h0, "os_irq_cleared");

        // Auto-reload timer
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'hB);
        rd(A_COUNT, 32'd2, "ar_start");
        tick(1);
        rd(A_COUNT, 32'd1, "ar_c1");
        tick(1);
        rd(A_COUNT, 32'd2, "ar_reload");
        rd(A_CTRL, 32'hF, "ar_flag");
        wr(A_CTRL, 32'hF);
        rd(A_COUNT, 32'd1, "ar_c1b");
        rd(A_CTRL, 32'hB, "ar_w1c");
        wr(A_CTRL, 32'hF);
        rd(A_COUNT, 32'd2, "ar_reload2");
        rd(A_CTRL, 32'hF, "ar_set_wins");
        sig(32'(timer_irq), 32'h1, "ar_irq");

        // Asynchronous reset between edges
        wr(A_LED, 32'hA5);
        wr(A_PRESET, 32'd5);
        rd(A_COUNT, 32'd5, "ar_pre_rst_count");
        rst = 1'b1;
        #1;
        sig(32'(led), 32'h0, "arst_led");
        sig(32'(timer_irq), 32'h0, "arst_irq");
        rd(A_COUNT, 32'h0, "arst_count");
        rd(A_CTRL, 32'h0, "arst_ctrl");
        rst = 1'b0;
        rd(32'h10, 32'h1111_1111, "arst_ram_kept");
        rd(32'hFFC, 32'h0BAD_F00D, "arst_ram_top_kept");
        tick(2);
        rd(A_COUNT, 32'h0, "arst_count_idle");

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
